// File: rtl/axi_lite_arbiter.sv
// AXI-Lite 2:1 arbiter: two masters share one slave, one transaction in flight,
// round-robin between masters on simultaneous requests.
module axi_lite_arbiter #(
  parameter bit READ_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] m0_ARdata,
  input  logic [31:0] m1_ARdata,
  output logic [31:0] ARdata,
  input  logic        m0_ARvalid,
  input  logic        m1_ARvalid,
  output logic        ARvalid,
  output logic        m0_ARready,
  output logic        m1_ARready,
  input  logic        ARready,
  output logic [31:0] m0_Rdata,
  output logic [31:0] m1_Rdata,
  input  logic [31:0] Rdata,
  output logic        m0_Rvalid,
  output logic        m1_Rvalid,
  input  logic        Rvalid,
  input  logic        m0_Rready,
  input  logic        m1_Rready,
  output logic        Rready,
  input  logic [31:0] m0_AWdata,
  input  logic [31:0] m1_AWdata,
  output logic [31:0] AWdata,
  input  logic        m0_AWvalid,
  input  logic        m1_AWvalid,
  output logic        AWvalid,
  output logic        m0_AWready,
  output logic        m1_AWready,
  input  logic        AWready,
  input  logic [31:0] m0_Wdata,
  input  logic [31:0] m1_Wdata,
  input  logic [3:0]  m0_Wstrb,
  input  logic [3:0]  m1_Wstrb,
  output logic [31:0] Wdata,
  output logic [3:0]  Wstrb,
  input  logic        m0_Wvalid,
  input  logic        m1_Wvalid,
  output logic        Wvalid,
  output logic        m0_Wready,
  output logic        m1_Wready,
  input  logic        Wready,
  output logic        m0_Bvalid,
  output logic        m1_Bvalid,
  input  logic        Bvalid,
  input  logic        m0_Bready,
  input  logic        m1_Bready,
  output logic        Bready,
  output logic        gnt,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_e;

  state_e state_q, state_d;
  logic   gnt_q, gnt_d, last_q, last_d;
  logic   ar_done_q, ar_done_d, aw_done_q, aw_done_d, w_done_q, w_done_d;

  logic        own_arvalid, own_rready, own_awvalid, own_wvalid, own_bready;
  logic [31:0] own_ardata, own_awdata, own_wdata;
  logic [3:0]  own_wstrb;
  logic        ar_rdy, r_vld, aw_rdy, w_rdy, b_vld;
  logic [31:0] r_data;
  logic        req0, req1, win, win_ar, win_aw;

  always_comb begin
    own_arvalid = gnt_q ? m1_ARvalid : m0_ARvalid;
    own_ardata  = gnt_q ? m1_ARdata  : m0_ARdata;
    own_rready  = gnt_q ? m1_Rready  : m0_Rready;
    own_awvalid = gnt_q ? m1_AWvalid : m0_AWvalid;
    own_awdata  = gnt_q ? m1_AWdata  : m0_AWdata;
    own_wvalid  = gnt_q ? m1_Wvalid  : m0_Wvalid;
    own_wdata   = gnt_q ? m1_Wdata   : m0_Wdata;
    own_wstrb   = gnt_q ? m1_Wstrb   : m0_Wstrb;
    own_bready  = gnt_q ? m1_Bready  : m0_Bready;
  end

  // Slave-side outputs and the owner-side return path; everything is zero in IDLE.
  always_comb begin
    ARdata  = '0;
    ARvalid = 1'b0;
    Rready  = 1'b0;
    AWdata  = '0;
    AWvalid = 1'b0;
    Wdata   = '0;
    Wstrb   = '0;
    Wvalid  = 1'b0;
    Bready  = 1'b0;
    ar_rdy  = 1'b0;
    r_vld   = 1'b0;
    r_data  = '0;
    aw_rdy  = 1'b0;
    w_rdy   = 1'b0;
    b_vld   = 1'b0;
    unique case (state_q)
      READ: begin
        ARdata  = own_ardata;
        ARvalid = own_arvalid & ~ar_done_q;
        ar_rdy  = ARready & ~ar_done_q;
        r_vld   = Rvalid;
        r_data  = Rdata;
        Rready  = own_rready;
      end
      WRITE: begin
        AWdata  = own_awdata;
        AWvalid = own_awvalid & ~aw_done_q;
        aw_rdy  = AWready & ~aw_done_q;
        Wdata   = own_wdata;
        Wstrb   = own_wstrb;
        Wvalid  = own_wvalid & ~w_done_q;
        w_rdy   = Wready & ~w_done_q;
        // B is only meaningful once both address and data have been accepted
        b_vld   = Bvalid & aw_done_q & w_done_q;
        Bready  = own_bready & aw_done_q & w_done_q;
      end
      default: ;
    endcase
  end

  assign m0_ARready = ar_rdy & ~gnt_q;
  assign m1_ARready = ar_rdy &  gnt_q;
  assign m0_Rvalid  = r_vld  & ~gnt_q;
  assign m1_Rvalid  = r_vld  &  gnt_q;
  assign m0_Rdata   = gnt_q ? '0 : r_data;
  assign m1_Rdata   = gnt_q ? r_data : '0;
  assign m0_AWready = aw_rdy & ~gnt_q;
  assign m1_AWready = aw_rdy &  gnt_q;
  assign m0_Wready  = w_rdy  & ~gnt_q;
  assign m1_Wready  = w_rdy  &  gnt_q;
  assign m0_Bvalid  = b_vld  & ~gnt_q;
  assign m1_Bvalid  = b_vld  &  gnt_q;
  assign gnt        = gnt_q;
  assign busy       = (state_q != IDLE);

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    last_d    = last_q;
    ar_done_d = ar_done_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    req0      = m0_ARvalid | m0_AWvalid;
    req1      = m1_ARvalid | m1_AWvalid;
    win       = (req0 & req1) ? ~last_q : req1;
    win_ar    = win ? m1_ARvalid : m0_ARvalid;
    win_aw    = win ? m1_AWvalid : m0_AWvalid;
    unique case (state_q)
      IDLE: begin
        ar_done_d = 1'b0;
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        if (req0 | req1) begin
          gnt_d   = win;
          state_d = (win_ar & (~win_aw | READ_FIRST)) ? READ : WRITE;
        end
      end
      READ: begin
        if (ARvalid & ARready) ar_done_d = 1'b1;
        if (Rvalid & Rready) begin
          state_d = IDLE;
          last_d  = gnt_q;
        end
      end
      WRITE: begin
        if (AWvalid & AWready) aw_done_d = 1'b1;
        if (Wvalid & Wready)   w_done_d  = 1'b1;
        if (Bvalid & Bready) begin
          state_d = IDLE;
          last_d  = gnt_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= IDLE;
      gnt_q     <= 1'b0;
      last_q    <= 1'b1;
      ar_done_q <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      last_q    <= last_d;
      ar_done_q <= ar_done_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

endmodule

// File: doc/axi_lite_arbiter.md
AXI_LITE_ARBITER -- requirements
Module: axi_lite_arbiter

Interface
REQ-001 Parameter READ_FIRST, default 1: when one master asserts ARvalid and AWvalid together, 1 grants the read first and 0 grants the write first.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rstn  input  1  reset, synchronous, active-low.
REQ-004 m0_ARdata, m1_ARdata  input  32  read address per master; ARdata  output  32  read address to slave.
REQ-005 m0_ARvalid, m1_ARvalid  input  1; ARvalid  output  1  read-address valid.
REQ-006 m0_ARready, m1_ARready  output  1; ARready  input  1  read-address ready.
REQ-007 m0_Rdata, m1_Rdata  output  32; Rdata  input  32  read data.
REQ-008 m0_Rvalid, m1_Rvalid  output  1; Rvalid  input  1  read-data valid.
REQ-009 m0_Rready, m1_Rready  input  1; Rready  output  1  read-data ready.
REQ-010 m0_AWdata, m1_AWdata  input  32; AWdata  output  32  write address.
REQ-011 m0_AWvalid, m1_AWvalid  input  1; AWvalid  output  1.
REQ-012 m0_AWready, m1_AWready  output  1; AWready  input  1.
REQ-013 m0_Wdata/m0_Wstrb, m1_Wdata/m1_Wstrb  input  32/4; Wdata/Wstrb  output  32/4  write data and byte strobes.
REQ-014 m0_Wvalid, m1_Wvalid  input  1; Wvalid  output  1.  m0_Wready, m1_Wready  output  1; Wready  input  1.
REQ-015 m0_Bvalid, m1_Bvalid  output  1; Bvalid  input  1.  m0_Bready, m1_Bready  input  1; Bready  output  1.
REQ-016 gnt  output  1  current owner (0 = m0, 1 = m1); busy  output  1  high outside IDLE.

Function
REQ-017 FSM states: IDLE, READ, WRITE; exactly one transaction is in flight at a time.
REQ-018 Request of master N = mN_ARvalid | mN_AWvalid, sampled in IDLE only.
REQ-019 IDLE with a single requester: that master is granted; next state is READ or WRITE, chosen per REQ-001.
REQ-020 IDLE with both requesting: round-robin, the master not served last wins; last-served register resets to 1, so m0 wins the first tie.
REQ-021 Grant latency: the slave-side valid asserts the cycle after the IDLE cycle in which the request was seen.
REQ-022 READ: ARvalid = owner ARvalid & ~ar_done; ar_done sets on ARvalid & ARready; owner ARready = ARready & ~ar_done.
REQ-023 READ: Rdata, Rvalid and Rready are routed between the slave and the owner; Rvalid & Rready returns the FSM to IDLE and updates last-served.
REQ-024 WRITE: AW and W are forwarded independently, each blocked after its own handshake (aw_done, w_done); either order, or the same cycle, is legal.
REQ-025 WRITE ends on Bvalid & Bready (only valid once aw_done & w_done), then IDLE; last-served is updated.
REQ-026 Non-owner master, and both masters in IDLE: all ready/valid outputs toward it are 0 and its data outputs are 0.
REQ-027 In IDLE, all slave-side valid/ready outputs are 0 and address/data outputs are 0.
REQ-028 Owner data/address buses pass combinationally to the slave; gnt, state and done flags are registers.
REQ-029 Requests from the non-owner are held pending and never dropped; the owner cannot regain the grant while the other master is requesting at return to IDLE.
REQ-030 A response that arrives with Rvalid or Bvalid while the FSM is in the wrong state is ignored, with Rready/Bready held at 0.

Reset
REQ-031 rstn = 0 at a rising edge forces: state IDLE, gnt 0, busy 0, ar_done/aw_done/w_done 0, last-served 1, all valid/ready outputs 0 from the next cycle.
REQ-032 Reset mid-transaction abandons it; after release the FSM behaves as after power-up.

Verification
REQ-033 m0 read only, ARdata 0x100, slave ARready at +1 and Rvalid with Rdata 0xDEADBEEF at +3 -> m0_Rdata = 0xDEADBEEF, busy falls the cycle after R handshake, gnt = 0.
REQ-034 m0 read and m1 write requested in the same cycle from reset -> m0 served first, then m1 write (AWdata 0x200, Wdata 0x55AA55AA, Wstrb 0xF) reaches the slave; m1 sees Bvalid.
REQ-035 Back-to-back tie repeated 4 times -> grants alternate 0,1,0,1.
REQ-036 m1 write with Wready asserted two cycles before AWready -> Wvalid drops after its handshake, AWvalid held until AWready, and exactly one B is routed to m1.
REQ-037 rstn low for 1 cycle during READ after AR handshake, with a late Rvalid from the slave -> Rready stays 0, m0_Rvalid stays 0, state IDLE.
REQ-038 READ_FIRST = 0, m0 asserts ARvalid and AWvalid together -> WRITE taken first, then READ.
